// File: rtl/reg_file_sb.sv
// Integer register file with write-through bypass, per-register busy scoreboard
// and a post-reset clear sweep that zeroes one register per cycle.

module reg_file_sb_entry #(
    parameter int XLEN      = 32,
    parameter int IDX       = 0,
    parameter bit HARD_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            wr,
    input  logic [XLEN-1:0] wdata,
    input  logic            set_busy,
    input  logic            clr_busy,
    output logic [XLEN-1:0] q,
    output logic            busy
);
    generate
        if (HARD_ZERO && IDX == 0) begin : g_zero
            // Hardwired zero register: no storage, never pending.
            logic unused_in;
            assign unused_in = ^{clk, reset, clr, wr, wdata, set_busy, clr_busy};
            assign q    = '0;
            assign busy = 1'b0;
        end else begin : g_reg
            logic [XLEN-1:0] data_q;
            logic            busy_q;

            always_ff @(posedge clk) begin
                if (clr)
                    data_q <= '0;
                else if (wr)
                    data_q <= wdata;
            end

            // Issue is applied after the write clear so a same-cycle reissue stays pending.
            always_ff @(posedge clk) begin
                if (reset)
                    busy_q <= 1'b0;
                else if (set_busy)
                    busy_q <= 1'b1;
                else if (clr_busy)
                    busy_q <= 1'b0;
            end

            assign q    = data_q;
            assign busy = busy_q;
        end
    endgenerate
endmodule

module reg_file_sb #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter bit HARD_ZERO = 1'b1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy1,
    output logic            busy2
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t                     state;
    logic [AW-1:0]              idx;
    logic                       run;
    logic                       wr_ok;
    logic [NREG-1:0][XLEN-1:0]  regs;
    logic [NREG-1:0]            busy_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == AW'(NREG - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign run   = (state == RUN);
    assign wr_ok = run && we && !(HARD_ZERO && waddr == '0);

    for (genvar i = 0; i < NREG; i++) begin : g_ent
        reg_file_sb_entry #(
            .XLEN      (XLEN),
            .IDX       (i),
            .HARD_ZERO (HARD_ZERO)
        ) u_ent (
            .clk      (clk),
            .reset    (reset),
            .clr      (state == CLEAR && idx == AW'(i)),
            .wr       (wr_ok && waddr == AW'(i)),
            .wdata    (wdata),
            .set_busy (run && issue_valid && issue_rd == AW'(i)),
            .clr_busy (wr_ok && waddr == AW'(i)),
            .q        (regs[i]),
            .busy     (busy_v[i])
        );
    end

    always_comb begin
        rdata1 = '0;
        if (run && !(HARD_ZERO && raddr1 == '0))
            rdata1 = (wr_ok && waddr == raddr1) ? wdata : regs[raddr1];
    end

    always_comb begin
        rdata2 = '0;
        if (run && !(HARD_ZERO && raddr2 == '0))
            rdata2 = (wr_ok && waddr == raddr2) ? wdata : regs[raddr2];
    end

    // A same-cycle writeback satisfies the reader, so it is not reported busy.
    assign busy1 = run && busy_v[raddr1] && !(we && waddr == raddr1);
    assign busy2 = run && busy_v[raddr2] && !(we && waddr == raddr2);
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default 32x32 instance plus a 16x64 instance.

module tb_reg_file_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_ready, a_we, a_iv, a_busy1, a_busy2;
    logic [4:0]  a_waddr, a_ird, a_ra1, a_ra2;
    logic [31:0] a_wdata, a_rd1, a_rd2;

    logic        b_reset, b_ready, b_we, b_iv, b_busy1, b_busy2;
    logic [3:0]  b_waddr, b_ird, b_ra1, b_ra2;
    logic [63:0] b_wdata, b_rd1, b_rd2;

    int pass_cnt = 0;
    int tot      = 0;

    reg_file_sb u_a (
        .clk(clk), .reset(a_reset), .ready(a_ready), .we(a_we), .waddr(a_waddr),
        .wdata(a_wdata), .issue_valid(a_iv), .issue_rd(a_ird), .raddr1(a_ra1),
        .raddr2(a_ra2), .rdata1(a_rd1), .rdata2(a_rd2), .busy1(a_busy1), .busy2(a_busy2)
    );

    reg_file_sb #(.XLEN(64), .NREG(16)) u_b (
        .clk(clk), .reset(b_reset), .ready(b_ready), .we(b_we), .waddr(b_waddr),
        .wdata(b_wdata), .issue_valid(b_iv), .issue_rd(b_ird), .raddr1(b_ra1),
        .raddr2(b_ra2), .rdata1(b_rd1), .rdata2(b_rd2), .busy1(b_busy1), .busy2(b_busy2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tot++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Wait for ready on the 32-entry file, poking we/issue during the sweep.
    task automatic wait_a(output int n);
        n = 0;
        while (!a_ready && n < 100) begin
            a_we = (n < 4) || (n == 30);
            a_waddr = (n == 30) ? 5'd3 : 5'(20 + n);
            a_wdata = 32'hBAD0_0000 + n;
            a_iv = (n < 4) || (n == 30);
            a_ird = (n == 30) ? 5'd3 : 5'd12;
            step();
            n++;
        end
        a_we = 0; a_iv = 0;
    endtask

    initial begin
        int n, errs;
        a_reset = 1; a_we = 0; a_waddr = 0; a_wdata = 0; a_iv = 0; a_ird = 0; a_ra1 = 0; a_ra2 = 0;
        b_reset = 1; b_we = 0; b_waddr = 0; b_wdata = 0; b_iv = 0; b_ird = 0; b_ra1 = 0; b_ra2 = 0;

        repeat (3) step();
        look();
        chk("rst_ready", a_ready, 0);
        chk("rst_busy", {a_busy1, a_busy2}, 0);

        a_reset = 0;
        wait_a(n);
        chk("ready_lat", n, 32);

        errs = 0;
        for (int i = 0; i < 32; i++) begin
            a_ra1 = 5'(i); a_ra2 = 5'(31 - i);
            #1;
            if (a_rd1 !== 0 || a_rd2 !== 0 || a_busy1 || a_busy2) errs++;
        end
        chk("clr_all_zero", errs, 0);
        step();

        // Bypass then readback
        a_we = 1; a_waddr = 5; a_wdata = 32'hDEADBEEF; a_ra1 = 5; a_ra2 = 6;
        look();
        chk("bypass_rd1", a_rd1, 32'hDEADBEEF);
        chk("bypass_rd2_other", a_rd2, 0);
        step();
        a_we = 0;
        look();
        chk("readback5", a_rd1, 32'hDEADBEEF);
        step();

        // Hard-zero register
        a_we = 1; a_waddr = 0; a_wdata = 32'h1234; a_iv = 1; a_ird = 0; a_ra1 = 0;
        look();
        chk("r0_bypass", a_rd1, 0);
        step();
        a_we = 0; a_iv = 0;
        look();
        chk("r0_rd", a_rd1, 0);
        chk("r0_busy", a_busy1, 0);
        step();

        // Issue / writeback on r7
        a_iv = 1; a_ird = 7; a_ra1 = 7;
        look();
        chk("own_dest_not_busy", a_busy1, 0);
        step();
        a_iv = 0;
        look();
        chk("busy7_set", a_busy1, 1);
        step();
        a_we = 1; a_waddr = 7; a_wdata = 32'h55;
        look();
        chk("busy7_wb_cycle", a_busy1, 0);
        chk("rd7_bypass", a_rd1, 32'h55);
        step();
        a_we = 0;
        look();
        chk("busy7_after", a_busy1, 0);
        chk("rd7_after", a_rd1, 32'h55);
        step();

        // Same-cycle issue and write on r9
        a_iv = 1; a_ird = 9;
        step();
        a_iv = 1; a_ird = 9; a_we = 1; a_waddr = 9; a_wdata = 32'hA; a_ra2 = 9;
        look();
        chk("busy9_bypass", a_busy2, 0);
        chk("rd9_bypass", a_rd2, 32'hA);
        step();
        a_iv = 0; a_we = 0;
        look();
        chk("busy9_reissue", a_busy2, 1);
        chk("rd9_data", a_rd2, 32'hA);
        step();

        // Mid-run reset
        a_we = 1; a_waddr = 3; a_wdata = 32'hFF; a_iv = 1; a_ird = 4;
        step();
        a_we = 0; a_iv = 0; a_ra1 = 3; a_ra2 = 4;
        look();
        chk("rd3_ff", a_rd1, 32'hFF);
        chk("busy4_set", a_busy2, 1);
        a_reset = 1;
        step();
        a_reset = 0;
        look();
        chk("midrst_ready", a_ready, 0);
        wait_a(n);
        chk("midrst_lat", n, 32);
        a_ra1 = 3; a_ra2 = 4;
        look();
        chk("rd3_cleared", a_rd1, 0);
        chk("busy4_cleared", a_busy2, 0);
        a_ra1 = 9; a_ra2 = 9;
        #1;
        chk("rd9_cleared", a_rd1, 0);
        chk("busy9_cleared", a_busy2, 0);
        a_ra1 = 12;
        #1;
        chk("busy12_clear_ign", a_busy1, 0);
        step();

        // 16 x 64 instance
        b_reset = 0;
        n = 0;
        while (!b_ready && n < 100) begin
            b_we = (n == 14); b_waddr = 4'd1; b_wdata = 64'hBAD;
            step();
            n++;
        end
        b_we = 0;
        chk("b_ready_lat", n, 16);
        b_we = 1; b_waddr = 15; b_wdata = 64'h0123_4567_89AB_CDEF; b_ra1 = 15; b_ra2 = 1;
        look();
        chk("b_bypass15", b_rd1, 64'h0123_4567_89AB_CDEF);
        chk("b_rd1_clr_ign", b_rd2, 0);
        step();
        b_we = 0; b_iv = 1; b_ird = 2; b_ra2 = 2;
        look();
        chk("b_rd15", b_rd1, 64'h0123_4567_89AB_CDEF);
        step();
        b_iv = 0;
        look();
        chk("b_busy2", b_busy2, 1);
        step();

        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule
